// File: rtl/pcpi_muldiv_pkg.sv
// rtl/pcpi_muldiv_pkg.sv - shared encodings and decode helpers for the RV32M PCPI co-processor
package pcpi_muldiv_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    F3_MUL    = 3'd0,
    F3_MULH   = 3'd1,
    F3_MULHSU = 3'd2,
    F3_MULHU  = 3'd3,
    F3_DIV    = 3'd4,
    F3_DIVU   = 3'd5,
    F3_REM    = 3'd6,
    F3_REMU   = 3'd7
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    DP_IDLE,
    DP_ITER,
    DP_FIX
  } div_phase_e;

  function automatic logic is_div(funct3_e f3);
    return f3 inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
  endfunction

  // MUL low word is sign-agnostic, so it rides the unsigned path
  function automatic logic rs1_signed(funct3_e f3);
    return f3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  endfunction

  function automatic logic rs2_signed(funct3_e f3);
    return f3 inside {F3_MULH, F3_DIV, F3_REM};
  endfunction

endpackage

// File: rtl/pcpi_div_iter.sv
// rtl/pcpi_div_iter.sv - iterative restoring divider with special-case bypass and sign fixup
module pcpi_div_iter
  import pcpi_muldiv_pkg::*;
#(
  parameter int DIV_BITS = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int ITERS = 32 / DIV_BITS;

  div_phase_e  phase_q, phase_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;

  logic [31:0] abs_dividend, abs_divisor;
  logic        special_zero, special_ovf;
  logic [32:0] step_r;
  logic [31:0] step_q;

  always_comb begin
    abs_dividend = (is_signed && dividend[31]) ? (~dividend + 32'd1) : dividend;
    abs_divisor  = (is_signed && divisor[31])  ? (~divisor + 32'd1)  : divisor;
    special_zero = (divisor == 32'd0);
    special_ovf  = is_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
  end

  // quo_q doubles as the dividend shift register; quotient bits fill in from the bottom
  always_comb begin
    step_r = {1'b0, rem_q};
    step_q = quo_q;
    for (int i = 0; i < DIV_BITS; i++) begin
      step_r = {step_r[31:0], step_q[31]};
      step_q = {step_q[30:0], 1'b0};
      if (step_r >= {1'b0, dvs_q}) begin
        step_r    = step_r - {1'b0, dvs_q};
        step_q[0] = 1'b1;
      end
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    unique case (phase_q)
      DP_IDLE: begin
        if (start) begin
          if (special_zero) begin
            quo_d   = 32'hFFFF_FFFF;
            rem_d   = dividend;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            phase_d = DP_FIX;
          end else if (special_ovf) begin
            quo_d   = 32'h8000_0000;
            rem_d   = 32'd0;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            phase_d = DP_FIX;
          end else begin
            quo_d   = abs_dividend;
            rem_d   = 32'd0;
            dvs_d   = abs_divisor;
            cnt_d   = 6'(ITERS);
            negq_d  = is_signed & (dividend[31] ^ divisor[31]);
            negr_d  = is_signed & dividend[31];
            phase_d = DP_ITER;
          end
        end
      end
      DP_ITER: begin
        rem_d = step_r[31:0];
        quo_d = step_q;
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          phase_d = DP_FIX;
        end
      end
      DP_FIX: begin
        phase_d = DP_IDLE;
      end
      default: begin
        phase_d = DP_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase_q <= DP_IDLE;
    end else begin
      phase_q <= phase_d;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q  <= cnt_d;
    rem_q  <= rem_d;
    quo_q  <= quo_d;
    dvs_q  <= dvs_d;
    negq_q <= negq_d;
    negr_q <= negr_d;
  end

  assign done      = (phase_q == DP_FIX);
  assign quotient  = negq_q ? (~quo_q + 32'd1) : quo_q;
  assign remainder = negr_q ? (~rem_q + 32'd1) : rem_q;

endmodule

// File: rtl/pcpi_muldiv.sv
// rtl/pcpi_muldiv.sv - RV32M PCPI co-processor: pipelined 33x33 multiplier plus optional iterative divider
module pcpi_muldiv
  import pcpi_muldiv_pkg::*;
#(
  parameter int MUL_STAGES = 2,
  parameter int ENABLE_DIV = 1,
  parameter int DIV_BITS   = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready
);

  funct3_e     insn_f3;
  logic        claim, accept;
  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        holdoff_q, holdoff_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic [31:0] rd_q, rd_d;
  funct3_e     f3_q, f3_d;

  logic [32:0] mul_a, mul_b;
  logic [63:0] mul_prod, mul_res;
  logic        div_start, div_done;
  logic [31:0] div_quo, div_rem;
  logic        unused_insn;

  assign insn_f3     = funct3_e'(pcpi_insn[14:12]);
  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  assign claim = pcpi_valid && (pcpi_insn[6:0] == OPC_OP) && (pcpi_insn[31:25] == F7_MULDIV)
                 && ((ENABLE_DIV != 0) || !is_div(insn_f3));
  // holdoff_q blocks a still-asserted pcpi_valid from re-issuing right after DONE
  assign accept = (state_q == ST_IDLE) && claim && !holdoff_q;

  assign mul_a    = {rs1_signed(f3_q) & rs1_q[31], rs1_q};
  assign mul_b    = {rs2_signed(f3_q) & rs2_q[31], rs2_q};
  assign mul_prod = {{31{mul_a[32]}}, mul_a} * {{31{mul_b[32]}}, mul_b};

  generate
    if (MUL_STAGES > 1) begin : g_mul_pipe
      logic [63:0] pipe_q [MUL_STAGES-1];
      logic [63:0] pipe_d [MUL_STAGES-1];
      always_comb begin
        pipe_d[0] = mul_prod;
        for (int i = 1; i < MUL_STAGES - 1; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end
      always_ff @(posedge clk) begin
        for (int i = 0; i < MUL_STAGES - 1; i++) begin
          pipe_q[i] <= pipe_d[i];
        end
      end
      assign mul_res = pipe_q[MUL_STAGES-2];
    end else begin : g_mul_comb
      assign mul_res = mul_prod;
    end
  endgenerate

  assign div_start = (state_q == ST_DIV) && (cnt_q == 3'd0);

  generate
    if (ENABLE_DIV != 0) begin : g_div
      pcpi_div_iter #(
        .DIV_BITS (DIV_BITS)
      ) u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (div_start),
        .is_signed (rs1_signed(f3_q)),
        .dividend  (rs1_q),
        .divisor   (rs2_q),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
      );
    end else begin : g_no_div
      logic unused_div;
      assign unused_div = div_start;
      assign div_done   = 1'b0;
      assign div_quo    = 32'd0;
      assign div_rem    = 32'd0;
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = 1'b0;
    holdoff_d = 1'b0;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = is_div(insn_f3) ? ST_DIV : ST_MUL;
          cnt_d   = 3'd0;
          rs1_d   = pcpi_rs1;
          rs2_d   = pcpi_rs2;
          f3_d    = insn_f3;
        end
      end
      ST_MUL: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(MUL_STAGES - 1)) begin
          state_d = ST_DONE;
          ready_d = 1'b1;
          rd_d    = (f3_q == F3_MUL) ? mul_res[31:0] : mul_res[63:32];
        end
      end
      ST_DIV: begin
        cnt_d = 3'd1;
        if (div_done) begin
          state_d = ST_DONE;
          ready_d = 1'b1;
          rd_d    = (f3_q == F3_REM || f3_q == F3_REMU) ? div_rem : div_quo;
        end
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        holdoff_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      ready_q   <= 1'b0;
      holdoff_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      holdoff_q <= holdoff_d;
    end
  end

  always_ff @(posedge clk) begin
    rs1_q <= rs1_d;
    rs2_q <= rs2_d;
    f3_q  <= f3_d;
    rd_q  <= rd_d;
  end

  // a core trap drops pcpi_valid; the finished result is then silently discarded
  assign pcpi_ready = ready_q & pcpi_valid;
  assign pcpi_wr    = pcpi_ready;
  assign pcpi_rd    = pcpi_ready ? rd_q : 32'd0;
  assign pcpi_wait  = resetn & claim & (state_q != ST_DONE);

endmodule

// File: tb/tb_pcpi_muldiv.sv
// tb/tb_pcpi_muldiv.sv - directed-vector bench for pcpi_muldiv across several parameter sets
module tb_pcpi_muldiv;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] insn, rs1, rs2;
  logic [3:0]  valid;
  logic [3:0]  wr, rdy, wt;
  logic [31:0] rd [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pcpi_muldiv #(.MUL_STAGES(1), .ENABLE_DIV(1), .DIV_BITS(1)) u0 (
    .clk(clk), .resetn(resetn), .pcpi_valid(valid[0]), .pcpi_insn(insn), .pcpi_rs1(rs1), .pcpi_rs2(rs2),
    .pcpi_wr(wr[0]), .pcpi_rd(rd[0]), .pcpi_wait(wt[0]), .pcpi_ready(rdy[0]));
  pcpi_muldiv #(.MUL_STAGES(2), .ENABLE_DIV(1), .DIV_BITS(2)) u1 (
    .clk(clk), .resetn(resetn), .pcpi_valid(valid[1]), .pcpi_insn(insn), .pcpi_rs1(rs1), .pcpi_rs2(rs2),
    .pcpi_wr(wr[1]), .pcpi_rd(rd[1]), .pcpi_wait(wt[1]), .pcpi_ready(rdy[1]));
  pcpi_muldiv #(.MUL_STAGES(3), .ENABLE_DIV(0), .DIV_BITS(1)) u2 (
    .clk(clk), .resetn(resetn), .pcpi_valid(valid[2]), .pcpi_insn(insn), .pcpi_rs1(rs1), .pcpi_rs2(rs2),
    .pcpi_wr(wr[2]), .pcpi_rd(rd[2]), .pcpi_wait(wt[2]), .pcpi_ready(rdy[2]));
  pcpi_muldiv #(.MUL_STAGES(4), .ENABLE_DIV(1), .DIV_BITS(4)) u3 (
    .clk(clk), .resetn(resetn), .pcpi_valid(valid[3]), .pcpi_insn(insn), .pcpi_rs1(rs1), .pcpi_rs2(rs2),
    .pcpi_wr(wr[3]), .pcpi_rd(rd[3]), .pcpi_wait(wt[3]), .pcpi_ready(rdy[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  task automatic issue(input int d, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_rd, input int exp_lat, input string tag);
    int   lat;
    logic wait_lost;
    @(negedge clk);
    insn     = mk(7'b0000001, f3);
    rs1      = a;
    rs2      = b;
    valid[d] = 1'b1;
    #1 check({tag, "_wait_pre"}, 32'(wt[d]), 32'd1);
    @(negedge clk);
    lat       = 0;
    wait_lost = 1'b0;
    while (!rdy[d] && lat < 200) begin
      if (!wt[d]) wait_lost = 1'b1;
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rd"}, rd[d], exp_rd);
    check({tag, "_wr"}, 32'(wr[d]), 32'd1);
    check({tag, "_wait_busy"}, 32'(wait_lost), 32'd0);
    check({tag, "_wait_done"}, 32'(wt[d]), 32'd0);
    // valid stays high through DONE and the holdoff cycle
    @(negedge clk);
    check({tag, "_pulse"}, 32'(rdy[d]), 32'd0);
    @(negedge clk);
    valid[d] = 1'b0;
  endtask

  task automatic expect_reject(input int d, input logic [31:0] word, input string tag);
    int   pulses;
    logic wait_seen;
    @(negedge clk);
    insn      = word;
    rs1       = 32'd100;
    rs2       = 32'd7;
    valid[d]  = 1'b1;
    pulses    = 0;
    wait_seen = 1'b0;
    repeat (100) begin
      #1;
      if (wt[d]) wait_seen = 1'b1;
      if (rdy[d]) pulses++;
      @(negedge clk);
    end
    valid[d] = 1'b0;
    check({tag, "_wait"}, 32'(wait_seen), 32'd0);
    check({tag, "_ready"}, 32'(pulses), 32'd0);
  endtask

  initial begin
    resetn = 1'b0;
    valid  = 4'b1111;
    insn   = mk(7'b0000001, 3'd0);
    rs1    = 32'd0;
    rs2    = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      check($sformatf("rst_ready%0d", d), 32'(rdy[d]), 32'd0);
      check($sformatf("rst_wait%0d", d), 32'(wt[d]), 32'd0);
      check($sformatf("rst_rd%0d", d), rd[d], 32'd0);
    end
    valid = 4'b0000;
    @(negedge clk);
    resetn = 1'b1;

    for (int d = 0; d < 4; d++) begin
      issue(d, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, d + 1, $sformatf("mul_s%0d", d + 1));
    end
    issue(1, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, "mulh");
    issue(1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, "mulhu");
    issue(1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, "mulhsu");

    issue(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_b1");
    issue(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem_b1");
    issue(1, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 18, "div_b2");
    issue(3, 3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 10, "div_b4");
    issue(3, 3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 10, "rem_b4");
    issue(1, 3'd5, 32'd100, 32'd7, 32'd14, 18, "divu");
    issue(1, 3'd7, 32'd100, 32'd7, 32'd2, 18, "remu");
    issue(3, 3'd5, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 10, "divu_big");
    issue(3, 3'd7, 32'hFFFF_FFFF, 32'h10, 32'hF, 10, "remu_big");

    issue(0, 3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 2, "divu_zero");
    issue(0, 3'd7, 32'd100, 32'd0, 32'd100, 2, "remu_zero");
    issue(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, "div_ovf");
    issue(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, "rem_ovf");

    @(negedge clk);
    insn     = mk(7'b0000001, 3'd4);
    rs1      = 32'hFFFF_FFF9;
    rs2      = 32'd2;
    valid[0] = 1'b1;
    repeat (6) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midrst_ready", 32'(rdy[0]), 32'd0);
    check("midrst_wr", 32'(wr[0]), 32'd0);
    check("midrst_wait", 32'(wt[0]), 32'd0);
    check("midrst_rd", rd[0], 32'd0);
    repeat (2) @(negedge clk);
    valid[0] = 1'b0;
    resetn   = 1'b1;
    issue(0, 3'd0, 32'd3, 32'd4, 32'd12, 1, "mul_after_rst");

    expect_reject(0, mk(7'b0000000, 3'd0), "add");
    expect_reject(2, mk(7'b0000001, 3'd4), "div_nodiv");
    issue(2, 3'd0, 32'd3, 32'd4, 32'd12, 3, "mul_after_reject");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pcpi_muldiv.md
Name: pcpi_muldiv

Overview:
- PCPI co-processor that executes the full RV32M extension for the picorv32 core: MUL/MULH/MULHSU/MULHU and DIV/DIVU/REM/REMU.
- Successor to the fixed-latency fast multiplier:
  - multiplier pipeline depth is parametrised;
  - adds an iterative divider with parametrised bits per cycle;
  - handles the RISC-V corner cases (divide by zero, signed overflow) in hardware.
- Sits on the core's PCPI bus, alongside or in place of the multiplier-only unit.

Parameters:
- MUL_STAGES, 2, cycles from accept to result for multiplies; legal range 1..4; registers are retimed into the 33x33 signed product.
- ENABLE_DIV, 1, when 0 the divide opcodes are not claimed (no wait, no ready) and no divider logic is built.
- DIV_BITS, 1, quotient bits resolved per cycle; legal values 1, 2 or 4.

Ports:
- clk  in  1  single clock.
- resetn  in  1  asynchronous, active-low reset.
- pcpi_valid  in  1  core presents an instruction; held high until pcpi_ready.
- pcpi_insn  in  32  instruction word.
- pcpi_rs1  in  32  operand 1.
- pcpi_rs2  in  32  operand 2.
- pcpi_wr  out  1  write rd; equals pcpi_ready.
- pcpi_rd  out  32  result; valid only while pcpi_ready=1, 0 otherwise.
- pcpi_wait  out  1  instruction is claimed and still executing.
- pcpi_ready  out  1  one-cycle completion pulse.

Behaviour:
- Decode:
  - claim = pcpi_valid & insn[6:0]==7'b0110011 & insn[31:25]==7'b0000001.
  - funct3 = insn[14:12]; values 0-3 are multiplies, 4-7 are divides.
  - Divides are claimed only if ENABLE_DIV=1.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE -> MUL or DIV on claim; this edge is the accept edge. rs1, rs2 and funct3 are captured on it.
  - MUL/DIV -> DONE when the result is ready.
  - DONE lasts exactly 1 cycle, then -> IDLE.
  - In DONE and on the first IDLE cycle after it, a still-high pcpi_valid is not re-accepted (one-cycle holdoff). This prevents double issue.
- pcpi_wait (combinational):
  - 1 when claim and (state==IDLE, or state is MUL/DIV, or held by the holdoff);
  - 0 in DONE;
  - 0 for unclaimed instructions.
- Multiply:
  - Each operand is extended to 33 bits: sign-extended if signed, zero-extended otherwise.
    - MULH: both signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - MULHU and MUL: both unsigned; the low word is identical either way.
  - The 64-bit product's low word goes to rd for MUL; the high word for MULH/MULHSU/MULHU.
  - pcpi_ready=1 on the cycle that starts exactly MUL_STAGES cycles after the accept edge.
- Divide:
  - Signed ops (DIV, REM) use absolute values and fix the sign afterwards.
    - Quotient sign = sign(rs1) XOR sign(rs2).
    - Remainder sign = sign(rs1).
  - Restoring division, DIV_BITS quotient bits per cycle.
  - Latency: ready at 32/DIV_BITS + 2 cycles after accept (1 setup cycle, the iterations, 1 sign-fixup cycle).
  - Divide by zero: quotient 0xFFFFFFFF, remainder = rs1. Ready 2 cycles after accept.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM): quotient 0x80000000, remainder 0. Ready 2 cycles after accept.
  - Results: quotient for DIV/DIVU, remainder for REM/REMU.
- pcpi_valid dropping mid-operation (core trap): the unit completes internally. The ready pulse is suppressed if pcpi_valid=0 on the ready cycle. The unit returns to IDLE.
- Reset:
  - resetn=0 at any time immediately forces state=IDLE and all outputs to 0.
  - Any in-flight operation is discarded.
  - Datapath registers need no reset.
- Only one instruction is ever in flight. No back-to-back overlap.

Decomposition:
- pcpi_muldiv_pkg holds:
  - OPC_OP=7'b0110011 and F7_MULDIV=7'b0000001;
  - a funct3 enum (F3_MUL..F3_REMU);
  - the state enum;
  - helper functions is_div(f3) and rs1_signed/rs2_signed(f3).
- Sub-module pcpi_div_iter holds the divider:
  - parameter DIV_BITS;
  - ports: start, is_signed, dividend, divisor, done, quotient, remainder;
  - it owns the special-case detection and sign fixup.
- The multiplier pipeline stays inline.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD with MUL_STAGES=1..4 -> pcpi_rd=0xFFFFFFEB, pcpi_wr=pcpi_ready=1 for exactly one cycle, MUL_STAGES cycles after accept; pcpi_wait=1 until then.
- High-word multiplies:
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide:
  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
  - Ready 34 cycles after accept for DIV_BITS=1, 18 cycles for DIV_BITS=2.
- Corner cases:
  - DIVU 100/0 -> 0xFFFFFFFF and REMU 100/0 -> 100.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0.
  - All ready 2 cycles after accept.
- resetn pulled low 5 cycles into a DIV -> pcpi_ready, pcpi_wr, pcpi_wait and pcpi_rd are 0 immediately. After release, MUL 3*4 -> 12 with normal latency.
- Rejected instructions -> pcpi_wait=0 and no ready pulse for 100 cycles:
  - funct7=0 (ADD);
  - a DIV when ENABLE_DIV=0.
- pcpi_valid held high through DONE -> exactly one ready pulse; no second issue.
